// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory, and buffers fetched words
// with their PCs in a 2-entry queue toward decode. Redirects flush the queue.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REDIRECT,
    input  logic [15:0] REDIRECT_PC,
    output logic [15:0] IMEM_ADDR,
    input  logic [31:0] IMEM_INSTR,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_INSTR,
    output logic [15:0] OUT_PC,
    output logic        ALIGN_FAULT
);

    typedef enum logic [0:0] {StFetch, StFault} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] q_instr_q [2];
    logic [15:0] q_pc_q [2];
    logic [31:0] hold_instr_q;
    logic [15:0] hold_pc_q;

    logic fetch_en;
    logic q_full;
    logic issue;
    logic pop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (REDIRECT) begin
            state_d = (REDIRECT_PC[1:0] == 2'b00) ? StFetch : StFault;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fetch_en    = 1'b0;
        ALIGN_FAULT = 1'b0;
        unique case (state_q)
            StFetch: fetch_en    = 1'b1;
            StFault: ALIGN_FAULT = 1'b1;
            default: ;
        endcase
    end

    // Issue ignores OUT_READY so there is no combinational ready-to-address path.
    assign q_full    = (count_q == 2'(QDEPTH));
    assign issue     = fetch_en && !q_full && !REDIRECT;
    assign OUT_VALID = (count_q != 2'd0);
    assign pop       = OUT_VALID && OUT_READY;
    assign IMEM_ADDR = pc_q;

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (REDIRECT) begin
            // Discards the in-flight word and any pop this cycle.
            pc_d     = REDIRECT_PC;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d     = pc_q + 16'd4;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({issue, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_instr_q[0] <= 32'd0;
            q_instr_q[1] <= 32'd0;
            q_pc_q[0]    <= 16'd0;
            q_pc_q[1]    <= 16'd0;
        end else if (issue) begin
            q_instr_q[wr_ptr_q] <= IMEM_INSTR;
            q_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    // Outputs hold the last presented entry while the queue is empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 16'd0;
        end else begin
            hold_instr_q <= OUT_INSTR;
            hold_pc_q    <= OUT_PC;
        end
    end

    always_comb begin
        OUT_INSTR = hold_instr_q;
        OUT_PC    = hold_pc_q;
        if (OUT_VALID) begin
            OUT_INSTR = q_instr_q[rd_ptr_q];
            OUT_PC    = q_pc_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic,
// compared against a queue-based reference model of the fetch stage.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REDIRECT;
    logic [15:0] REDIRECT_PC;
    logic [15:0] IMEM_ADDR;
    logic [31:0] IMEM_INSTR;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_INSTR;
    logic [15:0] OUT_PC;
    logic        ALIGN_FAULT;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_INSTR  (IMEM_INSTR),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_INSTR   (OUT_INSTR),
        .OUT_PC      (OUT_PC),
        .ALIGN_FAULT (ALIGN_FAULT)
    );

    always #5 CLK = ~CLK;

    // Instruction memory: word array, registered on the falling edge.
    logic [31:0] mem [0:16383];
    always @(negedge CLK) IMEM_INSTR <= mem[IMEM_ADDR[15:2]];

    // Reference model: fetch queue as an SV queue of {instr, pc}.
    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [15:0] m_pc;
    bit          m_fault;
    logic [31:0] m_last_instr;
    logic [15:0] m_last_pc;

    logic        e_valid;
    logic [31:0] e_instr;
    logic [15:0] e_pc;

    function automatic void refresh_expect();
        e_valid = (mq.size() != 0);
        e_instr = e_valid ? mq[0].instr : m_last_instr;
        e_pc    = e_valid ? mq[0].pc    : m_last_pc;
    endfunction

    function automatic void model_step(input bit rst_v, input bit redir_v,
                                       input logic [15:0] rpc_v, input bit rdy_v);
        bit     do_pop;
        bit     do_push;
        entry_t e;
        m_last_instr = e_instr;
        m_last_pc    = e_pc;
        if (rst_v) begin
            mq.delete();
            m_pc         = 16'h0000;
            m_fault      = 1'b0;
            m_last_instr = 32'd0;
            m_last_pc    = 16'd0;
        end else if (redir_v) begin
            mq.delete();
            m_pc    = rpc_v;
            m_fault = (rpc_v[1:0] != 2'b00);
        end else begin
            do_pop  = (mq.size() > 0) && rdy_v;
            do_push = !m_fault && (mq.size() < 2);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.instr = mem[m_pc[15:2]];
                e.pc    = m_pc;
                mq.push_back(e);
                m_pc = m_pc + 16'd4;
            end
        end
        refresh_expect();
    endfunction

    // One clock: drive inputs, advance DUT and model together, land 1 time unit after the edge.
    task automatic tick(input bit rst_v, input bit redir_v, input logic [15:0] rpc_v,
                        input bit rdy_v);
        RST         = rst_v;
        REDIRECT    = redir_v;
        REDIRECT_PC = rpc_v;
        OUT_READY   = rdy_v;
        @(posedge CLK);
        model_step(rst_v, redir_v, rpc_v, rdy_v);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 16'h0ABC, 1);
        tick(1, 0, 16'h0000, 1);
        n_tests++;
        if (OUT_VALID !== 1'b0 || OUT_INSTR !== 32'd0 || OUT_PC !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h, want 0/0/0",
                     OUT_VALID, OUT_INSTR, OUT_PC);
        end
        n_tests++;
        if (ALIGN_FAULT !== 1'b0 || IMEM_ADDR !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_addr: got fault=%b addr=%h, want 0/0000", ALIGN_FAULT, IMEM_ADDR);
        end
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        tick(1, 0, 16'h0000, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 16'h0000, 1);
            n_tests++;
            if (OUT_VALID !== 1'b1 || OUT_PC !== 16'(4 * i) || OUT_INSTR !== words[i]) begin
                n_fail++;
                $display("FAIL stream_%0d: got valid=%b pc=%h instr=%h, want 1 %h %h", i,
                         OUT_VALID, OUT_PC, OUT_INSTR, 16'(4 * i), words[i]);
            end
            n_tests++;
            if (IMEM_ADDR !== 16'(4 * i + 4)) begin
                n_fail++;
                $display("FAIL stream_addr_%0d: got %h want %h", i, IMEM_ADDR, 16'(4 * i + 4));
            end
        end
    endtask

    task automatic test_backpressure();
        tick(1, 0, 16'h0000, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 16'h0000, 0);
        n_tests++;
        if (IMEM_ADDR !== 16'h0008 || OUT_PC !== 16'h0000 || OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: got addr=%h pc=%h valid=%b, want 0008 0000 1",
                     IMEM_ADDR, OUT_PC, OUT_VALID);
        end
        for (int i = 1; i < 4; i++) begin
            tick(0, 0, 16'h0000, 1);
            n_tests++;
            if (OUT_VALID !== 1'b1 || OUT_PC !== 16'(4 * i) || OUT_INSTR !== mem[i]) begin
                n_fail++;
                $display("FAIL release_%0d: got valid=%b pc=%h instr=%h, want 1 %h %h", i,
                         OUT_VALID, OUT_PC, OUT_INSTR, 16'(4 * i), mem[i]);
            end
        end
    endtask

    task automatic test_redirect_flush();
        tick(1, 0, 16'h0000, 0);
        tick(0, 0, 16'h0000, 0);
        tick(0, 0, 16'h0000, 0);
        tick(0, 1, 16'h0100, 1);
        n_tests++;
        if (OUT_VALID !== 1'b0 || IMEM_ADDR !== 16'h0100) begin
            n_fail++;
            $display("FAIL flush_empty: got valid=%b addr=%h, want 0 0100", OUT_VALID, IMEM_ADDR);
        end
        tick(0, 0, 16'h0000, 1);
        n_tests++;
        if (OUT_VALID !== 1'b1 || OUT_PC !== 16'h0100 || OUT_INSTR !== mem[16'h0040]) begin
            n_fail++;
            $display("FAIL flush_target: got valid=%b pc=%h instr=%h, want 1 0100 %h",
                     OUT_VALID, OUT_PC, OUT_INSTR, mem[16'h0040]);
        end
    endtask

    task automatic test_align_fault();
        tick(0, 1, 16'h0102, 1);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (ALIGN_FAULT !== 1'b1 || OUT_VALID !== 1'b0 || IMEM_ADDR !== 16'h0102) begin
                n_fail++;
                $display("FAIL fault_hold_%0d: got fault=%b valid=%b addr=%h, want 1 0 0102", i,
                         ALIGN_FAULT, OUT_VALID, IMEM_ADDR);
            end
            tick(0, 0, 16'h0000, 1);
        end
        tick(0, 1, 16'h0200, 1);
        n_tests++;
        if (ALIGN_FAULT !== 1'b0 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: got fault=%b valid=%b, want 0 0", ALIGN_FAULT, OUT_VALID);
        end
        tick(0, 0, 16'h0000, 1);
        n_tests++;
        if (OUT_VALID !== 1'b1 || OUT_PC !== 16'h0200 || OUT_INSTR !== mem[16'h0080]) begin
            n_fail++;
            $display("FAIL fault_resume: got valid=%b pc=%h instr=%h, want 1 0200 %h",
                     OUT_VALID, OUT_PC, OUT_INSTR, mem[16'h0080]);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] pcs [3];
        pcs[0] = 16'hFFF8;
        pcs[1] = 16'hFFFC;
        pcs[2] = 16'h0000;
        tick(0, 1, 16'hFFF8, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 16'h0000, 1);
            n_tests++;
            if (OUT_VALID !== 1'b1 || OUT_PC !== pcs[i] || OUT_INSTR !== mem[pcs[i][15:2]]) begin
                n_fail++;
                $display("FAIL wrap_%0d: got valid=%b pc=%h instr=%h, want 1 %h %h", i,
                         OUT_VALID, OUT_PC, OUT_INSTR, pcs[i], mem[pcs[i][15:2]]);
            end
        end
    endtask

    task automatic test_rst_over_redirect();
        tick(0, 1, 16'h0300, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 16'h0000, 0);
        tick(1, 1, 16'h0444, 1);
        n_tests++;
        if (OUT_VALID !== 1'b0 || OUT_INSTR !== 32'd0 || OUT_PC !== 16'd0 ||
            ALIGN_FAULT !== 1'b0 || IMEM_ADDR !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_redirect: got valid=%b instr=%h pc=%h fault=%b addr=%h, want zeros",
                     OUT_VALID, OUT_INSTR, OUT_PC, ALIGN_FAULT, IMEM_ADDR);
        end
    endtask

    task automatic test_random();
        bit          r_rst;
        bit          r_redir;
        logic [15:0] r_pc;
        tick(1, 0, 16'h0000, 1);
        for (int i = 0; i < 600; i++) begin
            r_rst   = ($urandom_range(0, 79) == 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_pc    = 16'($urandom);
            if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
            tick(r_rst, r_redir, r_pc, 1'($urandom_range(0, 1)));
            n_tests++;
            if (OUT_VALID !== e_valid || OUT_PC !== e_pc || OUT_INSTR !== e_instr ||
                IMEM_ADDR !== m_pc || ALIGN_FAULT !== m_fault) begin
                n_fail++;
                $display("FAIL random_%0d: got v=%b pc=%h in=%h addr=%h f=%b, want v=%b pc=%h in=%h addr=%h f=%b",
                         i, OUT_VALID, OUT_PC, OUT_INSTR, IMEM_ADDR, ALIGN_FAULT,
                         e_valid, e_pc, e_instr, m_pc, m_fault);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        m_pc         = 16'h0000;
        m_fault      = 1'b0;
        m_last_instr = 32'd0;
        m_last_pc    = 16'd0;
        refresh_expect();
        RST         = 1'b1;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 16'h0000;
        OUT_READY   = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_align_fault();
        test_wrap();
        test_rst_over_redirect();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory's 16-bit byte address.
- Captures the 32-bit little-endian word the memory returns, which is registered on the falling edge. Pairs each word with its PC in a 2-entry output queue and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects and flushes any fetched-but-unconsumed instructions when one arrives.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset. Must be 4-byte aligned.
- QDEPTH, 2, output queue depth. Fixed at 2; the implementation need not support other values.

Ports:
- CLK  input  1  system clock. All state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REDIRECT  input  1  load a new PC and flush the queue.
- REDIRECT_PC  input  16  target byte address, sampled when REDIRECT=1.
- IMEM_ADDR  output  16  byte address to instruction memory; equals the PC register.
- IMEM_INSTR  input  32  word returned by instruction memory for the address held in the current cycle.
- OUT_VALID  output  1  queue head holds a valid instruction.
- OUT_READY  input  1  decode accepts the head this cycle.
- OUT_INSTR  output  32  instruction at the queue head.
- OUT_PC  output  16  PC of the queue head.
- ALIGN_FAULT  output  1  high while in the FAULT state.

Behaviour:
- Reset (RST=1 at a rising edge): PC=RESET_PC, queue count=0, rd/wr pointers=0, state=FETCH. Outputs: OUT_VALID=0, OUT_INSTR=0, OUT_PC=0, ALIGN_FAULT=0, IMEM_ADDR=RESET_PC. RST overrides REDIRECT and every other input.
- Memory timing: IMEM_ADDR is held stable for the whole cycle. Memory samples it on the falling edge, so IMEM_INSTR at the next rising edge corresponds to that address. Fetch latency is 1 cycle, address to capture.
- issue = (state==FETCH) && (count<2) && !REDIRECT. This deliberately does not depend on OUT_READY, so there is no combinational ready-to-address path.
- On issue: push {IMEM_INSTR, PC} at wr_ptr and set PC<=PC+4, modulo 2^16 (16'hFFFC wraps to 16'h0000). Without issue, PC holds and the memory simply re-reads the same word.
- pop = OUT_VALID && OUT_READY, which advances rd_ptr.
- OUT_VALID = (count!=0). OUT_INSTR and OUT_PC come from the entry at rd_ptr. Both hold their last values when count=0.
- Count update:
  - push and pop together: count unchanged, order preserved.
  - push only: count+1.
  - pop only: count-1.
  - At count=1, push and pop in the same cycle sustains 1 instruction per cycle.
  - Queue full (count=2): no issue; an accepted pop frees a slot for the following cycle.
- REDIRECT=1 (state FETCH or FAULT):
  - count<=0, pointers<=0.
  - The in-flight word and any pop that cycle are discarded.
  - PC<=REDIRECT_PC.
  - If REDIRECT_PC[1:0]==0, state<=FETCH; otherwise state<=FAULT.
  - OUT_VALID is 0 in the cycle after a redirect.
- States:
  - FETCH: issuing normally.
  - FAULT: no issue, OUT_VALID=0, ALIGN_FAULT=1, IMEM_ADDR shows the faulting PC. Leaves only on RST (to FETCH at RESET_PC) or on an aligned REDIRECT (to FETCH).
- First valid output appears 1 cycle after reset deasserts or after an aligned redirect.

Test Plan:
- Reset, then memory preloaded with words 0x11111111, 0x22222222, 0x33333333 at 0, 4, 8, OUT_READY=1. Required: OUT_VALID rises 1 cycle after reset; OUT_PC=0,4,8 with matching words on consecutive cycles; IMEM_ADDR advances by 4 each cycle.
- Hold OUT_READY=0 for 5 cycles. Required: count saturates at 2, PC frozen at 16'h0008, OUT_PC stays 0. Release OUT_READY: order 0, 4, 8 with no duplicates or gaps.
- Queue holding PCs 0 and 4, then REDIRECT with REDIRECT_PC=16'h0100. Required: next cycle OUT_VALID=0; the cycle after, OUT_PC=16'h0100 with RAM[0x100..0x103]; PCs 0 and 4 never emitted.
- REDIRECT with REDIRECT_PC=16'h0102. Required: ALIGN_FAULT=1, OUT_VALID=0 indefinitely. An aligned REDIRECT to 16'h0200 clears the fault, and OUT_PC=16'h0200 appears next.
- REDIRECT to 16'hFFF8, OUT_READY=1. Required: OUT_PC sequence 16'hFFF8, 16'hFFFC, 16'h0000.
- Assert RST and REDIRECT together mid-stream with count=2. Required: reset values everywhere and PC=RESET_PC; REDIRECT_PC is ignored.
